rooth_inst_loader: RTL and testbench

//  Byte-stream boot loader upstream of the SoC instruction memory. Takes framed bytes
//  (e.g. UART RX), packs little-endian 32-bit words, writes them to inst mem, holds the

---
 rtl/rooth_inst_loader_pkg.sv | 19 +
 rtl/rooth_inst_loader_if.sv | 26 ++
 rtl/rooth_inst_loader_pack.sv | 46 ++++
 rtl/rooth_inst_loader.sv | 182 ++++++++++++++++++
 tb/tb_rooth_inst_loader.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rooth_inst_loader_pkg.sv
// Shared types and constants for the instruction boot loader.
//   state_e      : frame parser states
//   SYNC_BYTE_DEF: default frame start marker
//   LEN_BYTES    : width of the little-endian length field, in bytes
package rooth_inst_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_DATA = 3'd2,
    ST_CSUM = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } state_e;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'h5A;
  localparam int         LEN_BYTES     = 4;

endpackage

// File: rtl/rooth_inst_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
//   in_valid/in_data/in_ready : byte stream, transfer = in_valid & in_ready
//   mem_we/mem_addr/mem_wdata : one-cycle word write strobe, word address, packed word
// master = byte source / memory side, slave = loader side.
interface rooth_inst_loader_if #(
  parameter int ADDR_W = 12
) ();

  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/rooth_inst_loader_pack.sv
// Little-endian byte-to-word packer.
//   clk_i/rst_i  : clock, synchronous active-high reset
//   clr_i        : restart packing at byte 0 (frame start)
//   byte_vld_i/byte_dat_i : accepted byte
//   word_vld_o/word_dat_o : combinational, asserted with the 4th byte; byte0 in [7:0]
module rooth_loader_pack (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        byte_vld_i,
  input  logic [7:0]  byte_dat_i,
  output logic        word_vld_o,
  output logic [31:0] word_dat_o
);

  logic [1:0]  cnt_q, cnt_d;
  // Only the first three bytes need storing; the 4th is taken straight off the bus.
  // Bytes enter at the top and shift down, so byte0 ends up in [7:0].
  logic [23:0] sh_q, sh_d;

  always_comb begin
    cnt_d = cnt_q;
    sh_d  = sh_q;
    if (clr_i) begin
      cnt_d = 2'd0;
      sh_d  = 24'd0;
    end else if (byte_vld_i) begin
      cnt_d = cnt_q + 2'd1;
      sh_d  = {byte_dat_i, sh_q[23:8]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= 2'd0;
      sh_q  <= 24'd0;
    end else begin
      cnt_q <= cnt_d;
      sh_q  <= sh_d;
    end
  end

  assign word_vld_o = byte_vld_i && (cnt_q == 2'd3);
  assign word_dat_o = {byte_dat_i, sh_q};

endmodule

// File: rtl/rooth_inst_loader.sv
// Byte-stream boot loader: parses SYNC | N(LE32) | N words | XOR checksum frames,
// writes the words to instruction memory and releases cpu_hold on a good frame.
//   clk_i/rst_i : clock, synchronous active-high reset
//   bus         : byte stream in, instruction-memory write out (slave modport)
//   cpu_hold_o  : 1 = keep core in reset
//   load_done_o : sticky, last frame good;  load_err_o : sticky, last frame bad
module rooth_inst_loader
  import rooth_inst_loader_pkg::*;
#(
  parameter int         ADDR_W      = 12,
  parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF,
  parameter int         TIMEOUT_CYC = 1_000_000,
  parameter logic       HOLD_RST    = 1'b1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  rooth_inst_loader_if.slave bus,
  output logic               cpu_hold_o,
  output logic               load_done_o,
  output logic               load_err_o
);

  localparam int                TMO_W     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0]  TMO_MAX   = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [32:0]       MAX_WORDS = 33'd1 << ADDR_W;

  state_e              state_q, state_d;
  logic [31:0]         len_q, len_d;
  logic [ADDR_W:0]     words_q, words_d;
  logic [7:0]          csum_q, csum_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                in_ready_q, in_ready_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic                cpu_hold_q, cpu_hold_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic                xfer, in_frame, is_sync, pack_vld, tmo_hit;
  logic                len_too_big, last_word, csum_ok;
  logic [ADDR_W:0]     words_next;
  logic                pk_word_vld;
  logic [31:0]         pk_word_dat;

  assign xfer       = bus.in_valid && in_ready_q;
  assign in_frame   = state_q inside {ST_LEN, ST_DATA, ST_CSUM};
  // A sync byte only starts a frame outside one; inside a frame it is payload.
  assign is_sync    = xfer && !in_frame && (bus.in_data == SYNC_BYTE);
  assign pack_vld   = xfer && (state_q inside {ST_LEN, ST_DATA});
  assign tmo_hit    = in_frame && !xfer && (tmo_q == TMO_MAX);
  assign len_too_big = {1'b0, pk_word_dat} > MAX_WORDS;
  assign words_next = words_q + 1'b1;
  assign last_word  = (32'(words_next) == len_q);
  assign csum_ok    = (bus.in_data == csum_q);

  // Length field and data words share the same packer.
  rooth_loader_pack u_pack (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (is_sync),
    .byte_vld_i (pack_vld),
    .byte_dat_i (bus.in_data),
    .word_vld_o (pk_word_vld),
    .word_dat_o (pk_word_dat)
  );

  // State register (all registered outputs live here too).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      len_q       <= 32'd0;
      words_q     <= '0;
      csum_q      <= 8'd0;
      tmo_q       <= '0;
      in_ready_q  <= 1'b1;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'd0;
      cpu_hold_q  <= HOLD_RST;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      words_q     <= words_d;
      csum_q      <= csum_d;
      tmo_q       <= tmo_d;
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_hold_q  <= cpu_hold_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (is_sync) state_d = ST_LEN;
      end
      ST_LEN: begin
        if (pk_word_vld) begin
          if (len_too_big)               state_d = ST_ERR;
          else if (pk_word_dat == 32'd0) state_d = ST_CSUM;
          else                           state_d = ST_DATA;
        end else if (tmo_hit) begin
          state_d = ST_ERR;
        end
      end
      ST_DATA: begin
        if (pk_word_vld && last_word) state_d = ST_CSUM;
        else if (tmo_hit)             state_d = ST_ERR;
      end
      ST_CSUM: begin
        if (xfer)         state_d = csum_ok ? ST_DONE : ST_ERR;
        else if (tmo_hit) state_d = ST_ERR;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output / datapath next values.
  always_comb begin
    len_d       = len_q;
    words_d     = words_q;
    csum_d      = csum_q;
    in_ready_d  = 1'b1;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_hold_d  = cpu_hold_q;
    done_d      = done_q;
    err_d       = err_q;
    // Idle-gap counter; only meaningful inside a frame.
    tmo_d       = (in_frame && !xfer) ? tmo_q + 1'b1 : '0;

    if (is_sync) begin
      cpu_hold_d = 1'b1;
      done_d     = 1'b0;
      err_d      = 1'b0;
      mem_addr_d = '0;
      csum_d     = 8'd0;
      words_d    = '0;
      len_d      = 32'd0;
    end

    if (state_q == ST_LEN && pk_word_vld) len_d = pk_word_dat;

    if (state_q == ST_DATA && xfer) csum_d = csum_q ^ bus.in_data;

    // Write goes out the cycle after the 4th byte; input is stalled for that
    // cycle so writes can never be back to back. mem_addr carries the index of
    // the word being written, so it never wraps past N-1.
    if (state_q == ST_DATA && pk_word_vld) begin
      mem_we_d    = 1'b1;
      mem_wdata_d = pk_word_dat;
      mem_addr_d  = words_q[ADDR_W-1:0];
      words_d     = words_next;
      in_ready_d  = 1'b0;
    end

    if (state_d == ST_ERR && state_q != ST_ERR) err_d = 1'b1;
    if (state_d == ST_DONE && state_q != ST_DONE) begin
      done_d     = 1'b1;
      cpu_hold_d = 1'b0;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign cpu_hold_o    = cpu_hold_q;
  assign load_done_o   = done_q;
  assign load_err_o    = err_q;

endmodule

// File: tb/tb_rooth_inst_loader.sv
module tb_rooth_inst_loader;
  import rooth_inst_loader_pkg::*;

  localparam int ADDR_W = 12;
  localparam int TMO    = 300;

  logic clk = 1'b0;
  logic rst;
  logic cpu_hold, load_done, load_err;

  always #5 clk = ~clk;

  rooth_inst_loader_if #(.ADDR_W(ADDR_W)) ifc ();

  rooth_inst_loader #(
    .ADDR_W(ADDR_W), .SYNC_BYTE(SYNC_BYTE_DEF), .TIMEOUT_CYC(TMO), .HOLD_RST(1'b1)
  ) dut (
    .clk_i(clk), .rst_i(rst), .bus(ifc),
    .cpu_hold_o(cpu_hold), .load_done_o(load_done), .load_err_o(load_err)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [31:0]       d;
  } wr_t;

  int          checks = 0;
  int          failures = 0;
  wr_t         wr_q[$];
  logic [31:0] words[$];
  bit          prev_we = 1'b0;

  // Write monitor: records every memory write, flags back-to-back strobes and
  // input acceptance during a write cycle.
  always @(negedge clk) begin
    if (rst) begin
      prev_we = 1'b0;
    end else begin
      if (ifc.mem_we === 1'b1) begin
        wr_q.push_back('{a: ifc.mem_addr, d: ifc.mem_wdata});
        checks++;
        if (prev_we) begin
          failures++;
          $display("FAIL we_consecutive: mem_we=1 previous=1 required previous=0 at %0t", $time);
        end
        checks++;
        if (ifc.in_ready !== 1'b0) begin
          failures++;
          $display("FAIL ready_during_we: in_ready=%b required 0 at %0t", ifc.in_ready, $time);
        end
      end
      prev_we = (ifc.mem_we === 1'b1);
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    ifc.in_valid = 1'b0;
    ifc.in_data  = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_cycles(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int gap;
    int n;
    gap = $urandom_range(0, 2);
    repeat (gap) @(negedge clk);
    @(negedge clk);
    ifc.in_valid = 1'b1;
    ifc.in_data  = b;
    n = 0;
    while (ifc.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      failures++;
      $display("FAIL ready_wait: in_ready=%b required 1 within 50 cycles", ifc.in_ready);
    end
    @(posedge clk);
    #1 ifc.in_valid = 1'b0;
  endtask

  // Sync, length, the first nbytes of words[], optional checksum byte.
  task automatic send_frame(input logic [31:0] n, input int nbytes,
                            input logic [7:0] cs, input bit with_cs);
    logic [31:0] w;
    send_byte(SYNC_BYTE_DEF);
    for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8]);
    for (int i = 0; i < nbytes; i++) begin
      w = words[i/4];
      send_byte(w[8*(i%4) +: 8]);
    end
    if (with_cs) send_byte(cs);
  endtask

  function automatic logic [7:0] model_csum();
    logic [7:0] c = 8'h00;
    foreach (words[i])
      for (int k = 0; k < 4; k++) c = c ^ 8'((words[i] >> (8*k)) & 32'hFF);
    return c;
  endfunction

  task automatic load_t1();
    words.delete();
    words.push_back(32'h0000_0013);
    words.push_back(32'h0010_0093);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (ifc.in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready: got %b need 1", ifc.in_ready); end
    checks++; if (ifc.mem_we !== 1'b0) begin failures++; $display("FAIL rst_mem_we: got %b need 0", ifc.mem_we); end
    checks++; if (ifc.mem_addr !== '0) begin failures++; $display("FAIL rst_mem_addr: got %h need 0", ifc.mem_addr); end
    checks++; if (ifc.mem_wdata !== 32'd0) begin failures++; $display("FAIL rst_mem_wdata: got %h need 0", ifc.mem_wdata); end
    checks++; if (cpu_hold !== 1'b1) begin failures++; $display("FAIL rst_cpu_hold: got %b need 1", cpu_hold); end
    checks++; if (load_done !== 1'b0) begin failures++; $display("FAIL rst_done: got %b need 0", load_done); end
    checks++; if (load_err !== 1'b0) begin failures++; $display("FAIL rst_err: got %b need 0", load_err); end
  endtask

  task automatic test_basic();
    load_t1();
    wr_q.delete();
    send_frame(32'd2, 5, 8'h00, 1'b0);
    checks++; if (cpu_hold !== 1'b1) begin failures++; $display("FAIL t1_hold_mid: got %b need 1", cpu_hold); end
    for (int i = 5; i < 8; i++) send_byte(words[i/4][8*(i%4) +: 8]);
    send_byte(model_csum());
    wait_cycles(4);
    checks++; if (wr_q.size() !== 2) begin failures++; $display("FAIL t1_wr_count: got %0d need 2", wr_q.size()); end
    foreach (wr_q[i]) begin
      checks++;
      if (i < 2 && (wr_q[i].a !== ADDR_W'(i) || wr_q[i].d !== words[i])) begin
        failures++;
        $display("FAIL t1_wr%0d: got %h@%h need %h@%h", i, wr_q[i].d, wr_q[i].a, words[i], i);
      end
    end
    checks++; if (load_done !== 1'b1) begin failures++; $display("FAIL t1_done: got %b need 1", load_done); end
    checks++; if (load_err !== 1'b0) begin failures++; $display("FAIL t1_err: got %b need 0", load_err); end
    checks++; if (cpu_hold !== 1'b0) begin failures++; $display("FAIL t1_hold: got %b need 0", cpu_hold); end
  endtask

  task automatic test_bad_csum();
    load_t1();
    send_frame(32'd2, 8, 8'h00, 1'b1);
    wait_cycles(4);
    checks++; if (load_err !== 1'b1) begin failures++; $display("FAIL t2_err: got %b need 1", load_err); end
    checks++; if (load_done !== 1'b0) begin failures++; $display("FAIL t2_done: got %b need 0", load_done); end
    checks++; if (cpu_hold !== 1'b1) begin failures++; $display("FAIL t2_hold: got %b need 1", cpu_hold); end
  endtask

  task automatic test_garbage();
    load_t1();
    wr_q.delete();
    send_byte(8'h11);
    send_byte(8'h22);
    wait_cycles(3);
    checks++; if (ifc.mem_we !== 1'b0 || wr_q.size() !== 0) begin failures++; $display("FAIL t3_garbage_writes: got %0d need 0", wr_q.size()); end
    send_frame(32'd2, 8, model_csum(), 1'b1);
    wait_cycles(4);
    checks++; if (wr_q.size() !== 2) begin failures++; $display("FAIL t3_wr_count: got %0d need 2", wr_q.size()); end
    foreach (wr_q[i]) begin
      checks++;
      if (i < 2 && (wr_q[i].a !== ADDR_W'(i) || wr_q[i].d !== words[i])) begin
        failures++;
        $display("FAIL t3_wr%0d: got %h@%h need %h@%h", i, wr_q[i].d, wr_q[i].a, words[i], i);
      end
    end
    checks++; if (load_done !== 1'b1 || cpu_hold !== 1'b0) begin failures++; $display("FAIL t3_done: done=%b hold=%b need 1/0", load_done, cpu_hold); end
  endtask

  task automatic test_len_limits();
    words.delete();
    wr_q.delete();
    // One word past the memory: error straight after the length field.
    send_frame(32'h0000_1001, 0, 8'h00, 1'b0);
    wait_cycles(3);
    checks++; if (load_err !== 1'b1) begin failures++; $display("FAIL t4_err: got %b need 1", load_err); end
    for (int i = 0; i < 4; i++) send_byte(8'h00);
    wait_cycles(3);
    checks++; if (wr_q.size() !== 0) begin failures++; $display("FAIL t4_no_write: got %0d need 0", wr_q.size()); end
    // Exactly a full memory is accepted; abandoned frame then times out.
    send_frame(32'h0000_1000, 0, 8'h00, 1'b0);
    wait_cycles(3);
    checks++; if (load_err !== 1'b0 || cpu_hold !== 1'b1) begin failures++; $display("FAIL t4_full_ok: err=%b hold=%b need 0/1", load_err, cpu_hold); end
    wait_cycles(TMO + 4);
    checks++; if (load_err !== 1'b1) begin failures++; $display("FAIL t4_full_tmo: got %b need 1", load_err); end
    // Empty frame: checksum must be 0x00.
    send_frame(32'd0, 0, 8'h00, 1'b1);
    wait_cycles(3);
    checks++; if (load_done !== 1'b1 || load_err !== 1'b0) begin failures++; $display("FAIL t4_empty_good: done=%b err=%b need 1/0", load_done, load_err); end
    send_frame(32'd0, 0, 8'h01, 1'b1);
    wait_cycles(3);
    checks++; if (load_done !== 1'b0 || load_err !== 1'b1) begin failures++; $display("FAIL t4_empty_bad: done=%b err=%b need 0/1", load_done, load_err); end
    checks++; if (wr_q.size() !== 0) begin failures++; $display("FAIL t4_empty_writes: got %0d need 0", wr_q.size()); end
  endtask

  task automatic test_timeout();
    words.delete();
    for (int i = 0; i < 3; i++) words.push_back($urandom);
    send_frame(32'd3, 5, 8'h00, 1'b0);
    wait_cycles(TMO - 3);
    checks++; if (load_err !== 1'b0) begin failures++; $display("FAIL t5_early: got err=%b need 0", load_err); end
    wait_cycles(6);
    checks++; if (load_err !== 1'b1 || load_done !== 1'b0 || cpu_hold !== 1'b1) begin
      failures++; $display("FAIL t5_tmo: err=%b done=%b hold=%b need 1/0/1", load_err, load_done, cpu_hold);
    end
    send_frame(32'd3, 12, model_csum(), 1'b1);
    wait_cycles(4);
    checks++; if (load_done !== 1'b1 || load_err !== 1'b0) begin failures++; $display("FAIL t5_recover: done=%b err=%b need 1/0", load_done, load_err); end
  endtask

  task automatic test_rst_mid();
    load_t1();
    send_frame(32'd2, 6, 8'h00, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wr_q.delete();
    checks++; if (cpu_hold !== 1'b1 || load_done !== 1'b0 || load_err !== 1'b0) begin
      failures++; $display("FAIL t6_rst_flags: hold=%b done=%b err=%b need 1/0/0", cpu_hold, load_done, load_err);
    end
    checks++; if (ifc.mem_addr !== '0 || ifc.mem_wdata !== 32'd0) begin
      failures++; $display("FAIL t6_rst_mem: addr=%h data=%h need 0/0", ifc.mem_addr, ifc.mem_wdata);
    end
    send_frame(32'd2, 8, model_csum(), 1'b1);
    wait_cycles(4);
    checks++; if (wr_q.size() !== 2) begin failures++; $display("FAIL t6_wr_count: got %0d need 2", wr_q.size()); end
    foreach (wr_q[i]) begin
      checks++;
      if (i < 2 && (wr_q[i].a !== ADDR_W'(i) || wr_q[i].d !== words[i])) begin
        failures++;
        $display("FAIL t6_wr%0d: got %h@%h need %h@%h", i, wr_q[i].d, wr_q[i].a, words[i], i);
      end
    end
    checks++; if (load_done !== 1'b1) begin failures++; $display("FAIL t6_done: got %b need 1", load_done); end
  endtask

  task automatic test_random_frames();
    int          n;
    bit          good;
    logic [7:0]  cs;
    for (int it = 0; it < 8; it++) begin
      n = $urandom_range(1, 6);
      words.delete();
      for (int i = 0; i < n; i++) words.push_back($urandom);
      if (it == 0) words[0] = 32'h5A5A_005A;  // sync values inside payload
      good = ($urandom_range(0, 1) == 1);
      cs = model_csum();
      if (!good) cs = cs ^ 8'($urandom_range(1, 255));
      wr_q.delete();
      send_frame(32'(n), 4*n, cs, 1'b1);
      wait_cycles(4);
      checks++; if (wr_q.size() !== n) begin failures++; $display("FAIL rnd%0d_wr_count: got %0d need %0d", it, wr_q.size(), n); end
      foreach (wr_q[i]) begin
        checks++;
        if (i < n && (wr_q[i].a !== ADDR_W'(i) || wr_q[i].d !== words[i])) begin
          failures++;
          $display("FAIL rnd%0d_wr%0d: got %h@%h need %h@%h", it, i, wr_q[i].d, wr_q[i].a, words[i], i);
        end
      end
      checks++;
      if (load_done !== good || load_err !== !good || cpu_hold !== !good) begin
        failures++;
        $display("FAIL rnd%0d_status: done=%b err=%b hold=%b need %b/%b/%b",
                 it, load_done, load_err, cpu_hold, good, !good, !good);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    ifc.in_valid = 1'b0;
    ifc.in_data  = 8'h00;
    test_reset();
    test_basic();
    test_bad_csum();
    test_garbage();
    test_len_limits();
    test_timeout();
    test_rst_mid();
    test_random_frames();
    wait_cycles(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
